// File: rtl/spi_ram_master_ctrl.sv
// SPI master that turns single-byte bus reads/writes into 10-bit SPI RAM command frames,
// skipping the address frame when the slave's address register already holds req_addr.
module spi_ram_master_ctrl #(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_LAT     = 3,
  parameter int GAP_CYCLES = 1,
  parameter int SKIP_ADDR  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rw,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [7:0]           req_wdata,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_FRM, S_GAP, S_DATA_FRM, S_RD_CAP, S_DONE
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int             GW        = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0]  GAP_MAX   = GW'(GAP_CYCLES);
  localparam logic [4:0]     CAP_SS    = 5'd8;
  localparam logic [4:0]     CAP_FIRST = 5'(RD_LAT + 1);
  localparam logic [4:0]     CAP_LAST  = 5'(RD_LAT + 8);

  state_e                 state_q, state_d;
  logic                   ss_n_q, ss_n_d, mosi_q, mosi_d;
  logic                   rsp_valid_q, rsp_valid_d, busy_q, busy_d, req_ready_q, req_ready_d;
  logic [7:0]             rsp_rdata_q, rsp_rdata_d;
  logic                   rw_q, rw_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d, cache_addr_q, cache_addr_d;
  logic [7:0]             wdata_q, wdata_d, rx_q, rx_d;
  logic                   cache_vld_q, cache_vld_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [4:0]             cap_cnt_q, cap_cnt_d, cap_nxt;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
  logic [11:0]            tx_q, tx_d;
  logic [11:0]            addr_full, data_full, start_full;
  logic                   gap_ok, skip;

  // Full 12-bit frame image: two dummy zeros, then {cmd, byte} MSB first.
  assign addr_full  = {2'b00, (rw_q ? CMD_RD_ADDR : CMD_WR_ADDR), 8'(addr_q)};
  assign data_full  = {2'b00, (rw_q ? CMD_RD_DATA : CMD_WR_DATA), (rw_q ? 8'h00 : wdata_q)};
  assign start_full = (state_q == S_ADDR_FRM) ? addr_full : data_full;
  assign gap_ok     = (int'(gap_cnt_q) + 1) >= GAP_CYCLES;
  assign skip       = (SKIP_ADDR != 0) && cache_vld_q && (cache_addr_q == req_addr);
  assign cap_nxt    = cap_cnt_q + 5'd1;

  always_comb begin
    state_d      = state_q;
    ss_n_d       = ss_n_q;
    mosi_d       = mosi_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cache_vld_d  = cache_vld_q;
    cache_addr_d = cache_addr_q;
    bit_cnt_d    = bit_cnt_q;
    cap_cnt_d    = cap_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rw_d    = req_rw;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = skip ? S_DATA_FRM : S_ADDR_FRM;
        end
      end
      S_ADDR_FRM, S_DATA_FRM: begin
        if (ss_n_q) begin
          // Frame not yet started: hold SS_n high until the inter-frame gap is met.
          if (gap_ok) begin
            ss_n_d    = 1'b0;
            mosi_d    = start_full[11];
            tx_d      = {start_full[10:0], 1'b0};
            bit_cnt_d = 4'd0;
          end
        end else if (bit_cnt_q != 4'd11) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          mosi_d    = tx_q[11];
          tx_d      = {tx_q[10:0], 1'b0};
        end else begin
          mosi_d = 1'b0;
          if (state_q == S_ADDR_FRM) begin
            ss_n_d       = 1'b1;
            cache_vld_d  = 1'b1;
            cache_addr_d = addr_q;
            state_d      = S_GAP;
          end else if (rw_q) begin
            cap_cnt_d = 5'd0;
            rx_d      = 8'h00;
            state_d   = S_RD_CAP;
          end else begin
            ss_n_d      = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (gap_ok) begin
          ss_n_d    = 1'b0;
          mosi_d    = start_full[11];
          tx_d      = {start_full[10:0], 1'b0};
          bit_cnt_d = 4'd0;
          state_d   = S_DATA_FRM;
        end
      end
      S_RD_CAP: begin
        // cap_nxt counts edges after the command's last bit; SS_n may rise before bit 0.
        cap_cnt_d = cap_nxt;
        if (cap_nxt == CAP_SS) ss_n_d = 1'b1;
        if (cap_nxt >= CAP_FIRST && cap_nxt <= CAP_LAST) rx_d = {rx_q[6:0], MISO};
        if (cap_nxt == CAP_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = {rx_q[6:0], MISO};
          state_d     = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    gap_cnt_d = gap_cnt_q;
    if (!ss_n_q && ss_n_d)                  gap_cnt_d = '0;
    else if (ss_n_q && gap_cnt_q != GAP_MAX) gap_cnt_d = gap_cnt_q + 1'b1;

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ss_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 8'h00;
      busy_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 8'h00;
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
      bit_cnt_q    <= 4'd0;
      cap_cnt_q    <= 5'd0;
      gap_cnt_q    <= GAP_MAX;
      tx_q         <= 12'h000;
      rx_q         <= 8'h00;
    end else begin
      state_q      <= state_d;
      ss_n_q       <= ss_n_d;
      mosi_q       <= mosi_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      busy_q       <= busy_d;
      req_ready_q  <= req_ready_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cache_vld_q  <= cache_vld_d;
      cache_addr_q <= cache_addr_d;
      bit_cnt_q    <= bit_cnt_d;
      cap_cnt_q    <= cap_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

endmodule
